// File: rtl/programm_lader_pkg.sv
// Shared definitions for the UART program loader: default bit timing and the
// state encodings of the loader FSM and the UART receiver.
package programm_lader_pkg;

    // 25 MHz / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 217;

    typedef enum logic [1:0] {
        WARTE_LAENGE = 2'd0,
        EMPFANGE     = 2'd1,
        SCHREIBE     = 2'd2,
        FERTIG       = 2'd3
    } lader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/programm_lader_uart_empfaenger.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// byte_valid on a good stop bit and one-cycle frame_err on a bad one.
module uart_empfaenger
    import programm_lader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == HALF_CNT) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    valid_d    = sync2_q;
                    ferr_d     = !sync2_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/programm_lader.sv
// UART program loader: receives a length byte N (0 = 256) followed by N
// big-endian 32-bit words and writes them to instruction RAM from address 0.
module programm_lader
    import programm_lader_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEFAULT,
    parameter bit HALT_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_data,
    output logic        cpu_halt,
    output logic        busy,
    output logic        error
);
    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_empfaenger #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    lader_state_t state_q, state_d;
    logic [7:0]   len_q, len_d;
    logic [1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]   addr_q, addr_d;
    logic [31:0]  data_q, data_d;
    logic         halt_q, halt_d;
    logic         busy_q, busy_d;
    logic         error_q, error_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WARTE_LAENGE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            halt_q     <= HALT_AT_RESET;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        halt_d     = halt_q;
        busy_d     = busy_q;
        error_d    = error_q;
        case (state_q)
            WARTE_LAENGE, FERTIG: begin
                if (byte_valid) begin
                    len_d      = byte_data;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    halt_d     = 1'b1;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    state_d    = EMPFANGE;
                end
            end
            EMPFANGE: begin
                if (byte_valid) begin
                    data_d     = {data_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) state_d = SCHREIBE;
                end
            end
            SCHREIBE: begin
                // len_q - 1 wraps to 255 for N = 0, which encodes 256 words.
                if (addr_q == len_q - 8'd1) begin
                    state_d = FERTIG;
                    busy_d  = 1'b0;
                    halt_d  = 1'b0;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = EMPFANGE;
                end
            end
            default: state_d = WARTE_LAENGE;
        endcase
        // A framing error aborts any load but leaves the CPU halt state alone.
        if (frame_err) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = WARTE_LAENGE;
        end
    end

    assign ram_we   = (state_q == SCHREIBE);
    assign ram_addr = addr_q;
    assign ram_data = data_q;
    assign cpu_halt = halt_q;
    assign busy     = busy_q;
    assign error    = error_q;

endmodule

// File: tb/tb_programm_lader.sv
// Scoreboard bench for programm_lader: a reference model turns each load into
// expected (address, data) writes; a monitor checks every ram_we pulse.
module tb_programm_lader;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_data;
    logic        cpu_halt, busy, error;

    int vectors = 0;
    int miscompares = 0;
    logic [39:0] exp_q[$];

    programm_lader #(.CLKS_PER_BIT(CPB), .HALT_AT_RESET(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .cpu_halt (cpu_halt),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && ram_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr 0x%02h data 0x%08h, none expected", ram_addr, ram_data);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if ({ram_addr, ram_data} !== e) begin
                    miscompares++;
                    $display("FAIL write: got addr 0x%02h data 0x%08h expected addr 0x%02h data 0x%08h",
                             ram_addr, ram_data, e[39:32], e[31:0]);
                end else begin
                    $display("write addr 0x%02h data 0x%08h ok", ram_addr, ram_data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(posedge clk);
        end
        rx = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Reference model: word i of a load lands at address i, bytes MSB first.
    task automatic send_load(input logic [7:0] n, input logic [31:0] words[$]);
        int cnt;
        cnt = (n == 8'd0) ? 256 : int'(n);
        send_byte(n, 1'b1);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back({8'(i), words[i]});
            for (int k = 3; k >= 0; k--) send_byte(words[i][k*8 +: 8], 1'b1);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, (n < 200) ? 32'd0 : 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_status(input string name, input logic h, input logic b, input logic e);
        chk({name, "_halt"}, {31'd0, cpu_halt}, {31'd0, h});
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({name, "_error"}, {31'd0, error}, {31'd0, e});
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, "_we"}, {31'd0, ram_we}, 32'd0);
        chk({name, "_addr"}, {24'd0, ram_addr}, 32'd0);
        chk({name, "_data"}, ram_data, 32'd0);
        chk_status(name, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[$];
        int n;

        // Reset values
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk_reset_values("post_reset");

        // Basic two-word load
        w = '{32'h8040000F, 32'h4003FFFF};
        send_load(8'h02, w);
        wait_done("basic");
        chk_status("basic_done", 1'b0, 1'b0, 1'b0);
        chk("basic_last_addr", {24'd0, ram_addr}, 32'd1);

        // Single-cycle glitch must be ignored entirely
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        chk_status("glitch", 1'b0, 1'b0, 1'b0);

        // Framing error after a length byte
        send_byte(8'h01, 1'b1);
        send_byte(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        chk_status("frame_err", 1'b1, 1'b0, 1'b1);
        w = '{32'h00000001};
        send_load(8'h01, w);
        wait_done("after_err");
        chk_status("after_err", 1'b0, 1'b0, 1'b0);

        // Randomized loads
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            send_load(8'(n), w);
            wait_done("random");
            chk_status("random", 1'b0, 1'b0, 1'b0);
            chk("random_last_addr", {24'd0, ram_addr}, 32'(n - 1));
        end

        // From FERTIG: a new length byte raises cpu_halt again
        send_byte(8'h01, 1'b1);
        repeat (3) @(negedge clk);
        chk_status("restart", 1'b1, 1'b1, 1'b0);
        w = {$urandom};
        exp_q.push_back({8'h00, w[0]});
        for (int k = 3; k >= 0; k--) send_byte(w[0][k*8 +: 8], 1'b1);
        wait_done("restart");
        chk_status("restart_done", 1'b0, 1'b0, 1'b0);

        // N = 0 means 256 words, ending at address 255
        w = {};
        for (int i = 0; i < 256; i++) w.push_back(32'(i));
        send_load(8'h00, w);
        wait_done("n256");
        chk_status("n256", 1'b0, 1'b0, 1'b0);
        chk("n256_last_addr", {24'd0, ram_addr}, 32'd255);
        chk("n256_last_data", ram_data, 32'h000000FF);

        // Reset in the middle of a load
        send_byte(8'h03, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        chk_status("midload", 1'b1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 chk_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        w = {$urandom};
        send_load(8'h01, w);
        wait_done("reload");
        chk_status("reload", 1'b0, 1'b0, 1'b0);
        chk("reload_addr", {24'd0, ram_addr}, 32'd0);

        repeat (20) @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/programm_lader.md
PROGRAMM_LADER -- requirements
Module: programm_lader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217: clk cycles per UART bit (25 MHz / 115200).
REQ-002 Parameter HALT_AT_RESET, default 1: value of cpu_halt after reset.
REQ-003 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port rx, input, 1: UART receive line, 8N1, LSB first, idle high, asynchronous to clk.
REQ-006 Port ram_we, output, 1: one-cycle write strobe to instruction RAM.
REQ-007 Port ram_addr, output, 8: instruction RAM word address.
REQ-008 Port ram_data, output, 32: instruction word to write.
REQ-009 Port cpu_halt, output, 1: holds the CPU in reset while high.
REQ-010 Port busy, output, 1: high while a load is in progress.
REQ-011 Port error, output, 1: sticky framing-error flag.

Function
REQ-012 rx SHALL pass through a two-flop synchroniser before any use.
REQ-013 The receiver SHALL detect a start bit on a synchronised falling edge and re-check it at mid-bit (CLKS_PER_BIT/2); if rx is high there, it SHALL discard the start and return to idle.
REQ-014 The receiver SHALL sample 8 data bits and the stop bit at bit centres, then pulse an internal byte_valid for 1 cycle at the stop-bit sample.
REQ-015 A stop bit sampled low SHALL set error, suppress byte_valid, and return the loader to WARTE_LAENGE with busy low; cpu_halt SHALL keep its value.
REQ-016 Protocol: one length byte N (0 means 256), then N words of 4 bytes each, most significant byte first.
REQ-017 States: WARTE_LAENGE, EMPFANGE, SCHREIBE, FERTIG.
REQ-018 WARTE_LAENGE or FERTIG, on byte_valid: store N, clear ram_addr to 0 and the byte counter to 0, set cpu_halt=1, busy=1, error=0, and go to EMPFANGE, all in the same edge.
REQ-019 EMPFANGE, on byte_valid: shift the byte into ram_data from the bottom (ram_data <= {ram_data[23:0], byte}) and increment the 2-bit byte counter; after the 4th byte, go to SCHREIBE.
REQ-020 SCHREIBE: ram_we=1 for exactly 1 cycle, 1 cycle after the 4th byte_valid, with ram_addr and ram_data stable during that cycle.
REQ-021 After the write, when fewer than N words have been written: increment ram_addr and return to EMPFANGE.
REQ-022 After the write, when N words have been written: go to FERTIG, busy=0, cpu_halt=0 on the next cycle, and ram_addr holds the last address.
REQ-023 ram_addr SHALL never wrap within a load; N=256 ends at address 255.
REQ-024 ram_we SHALL be low in every state except SCHREIBE.
REQ-025 FERTIG persists until a new length byte arrives; bytes arriving during a load are never treated as headers.

Reset
REQ-026 On reset assertion, asynchronously: state=WARTE_LAENGE, receiver idle, ram_we=0, ram_addr=0, ram_data=0, busy=0, error=0, cpu_halt=HALT_AT_RESET, synchroniser flops=1.
REQ-027 A reset during a load SHALL abandon it with no further writes; the next byte after release is a length byte.

Structure
REQ-028 State encodings and the default CLKS_PER_BIT SHALL live in a shared include/package file used by the loader and the top-level.
REQ-029 The UART bit receiver SHALL be a sub-module named uart_empfaenger (synchroniser, bit timing, byte_valid, framing error); programm_lader contains the protocol FSM and RAM interface.
REQ-030 Top-level integration: ram_* feed the InstruktionRAM write port; cpu_halt ORs into the CPU reset.

Verification (CLKS_PER_BIT=4)
REQ-031 Reset, then send N=0x02, words 0x8040000F and 0x4003FFFF: two ram_we pulses, at addr 0 and addr 1, with exactly those data; then cpu_halt=0 and busy=0.
REQ-032 Glitch: rx low for 1 cycle only: no byte_valid, state unchanged, no error.
REQ-033 Framing error: send N=0x01, then a byte with stop bit 0: error=1, busy=0, no ram_we; next good N=0x01 + word 0x00000001 clears error and writes addr 0.
REQ-034 N=0x00 with 256 words of value index: last write at addr 255 with data 0x000000FF, no wrap, then cpu_halt=0.
REQ-035 Assert reset after 2 bytes of word 1 of an N=3 load: all outputs reach their reset values immediately; reload with N=0x01 writes addr 0.
REQ-036 From FERTIG, send a new N=0x01: cpu_halt rises the cycle after byte_valid, and the single word is written at addr 0.
